// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative RV M-extension multiply/divide unit on one shared shift/add-subtract datapath.
// Optional feature macro MULDIV_EARLY_OUT_EN: multiplies finish once the multiplier bits run out.
module muldiv_iter #(
    parameter int XLEN           = 64,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [3:0]      op_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);
    localparam int B  = BITS_PER_CYCLE;
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, PREP, CALC, DONE} state_t;

    state_t            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
    logic [XLEN-1:0]   x_q, x_d, y_q, y_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   result_q, result_d;

    function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
        sext32 = v;
        for (int i = 32; i < XLEN; i++) sext32[i] = v[31];
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [XLEN-1:0] v);
        zext32 = v;
        for (int i = 32; i < XLEN; i++) zext32[i] = 1'b0;
    endfunction

    logic is_div, is_rem, sgn_a, sgn_b, w_op;
    int   wsh;

    always_comb begin
        is_div = op_q[2];
        is_rem = op_q[2] & op_q[1];
        sgn_a  = is_div ? ~op_q[0] : (op_q[1] ^ op_q[0]);
        sgn_b  = is_div ? ~op_q[0] : (op_q[1:0] == 2'b01);
        w_op   = (XLEN == 64) && op_q[3];
        wsh    = w_op ? XLEN - 32 : 0;
    end

    // Operand conditioning and the single-cycle special cases evaluated in PREP.
    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_val, fast_raw, fast_res;
    logic            a_neg, b_neg, div0, ovf, mul_zero, fast;

    always_comb begin
        a_ext = w_op ? (sgn_a ? sext32(a_q) : zext32(a_q)) : a_q;
        b_ext = w_op ? (sgn_b ? sext32(b_q) : zext32(b_q)) : b_q;
        a_neg = sgn_a & a_ext[XLEN-1];
        b_neg = sgn_b & b_ext[XLEN-1];
        a_mag = a_neg ? -a_ext : a_ext;
        b_mag = b_neg ? -b_ext : b_ext;
        min_val = '0;
        if (w_op) begin
            for (int i = 31; i < XLEN; i++) min_val[i] = 1'b1;
        end else begin
            min_val[XLEN-1] = 1'b1;
        end
        div0 = is_div && (b_ext == '0);
        ovf  = is_div && sgn_a && (a_ext == min_val) && (b_ext == '1);
`ifdef MULDIV_EARLY_OUT_EN
        mul_zero = (op_q[2:0] == 3'd0) && ((a_ext == '0) || (b_ext == '0));
`else
        mul_zero = 1'b0;
`endif
        fast = div0 || ovf || mul_zero;
        if (div0)     fast_raw = is_rem ? a_ext : '1;
        else if (ovf) fast_raw = is_rem ? '0 : a_ext;
        else          fast_raw = '0;
        fast_res = w_op ? sext32(fast_raw) : fast_raw;
    end

    logic [XLEN+B-1:0] pp [B];
    for (genvar gi = 0; gi < B; gi++) begin : g_pp
        assign pp[gi] = y_q[gi] ? ({{B{1'b0}}, x_q} << gi) : '0;
    end

    // One iteration of shift-add multiply and restoring divide, plus the result fix-up.
    logic [XLEN+B-1:0] hi_sum;
    logic [2*XLEN-1:0] acc_mul, acc_div, prod;
    logic [XLEN-1:0]   y_next, quo, dres, calc_raw, calc_res;
    logic [XLEN:0]     rem;
    logic              early, calc_done;
    int                mshift;

    always_comb begin
        hi_sum = {{B{1'b0}}, acc_q[2*XLEN-1:XLEN]};
        for (int i = 0; i < B; i++) hi_sum = hi_sum + pp[i];
        acc_mul = {hi_sum, acc_q[XLEN-1:B]};
        y_next  = y_q >> B;

        rem = {1'b0, acc_q[2*XLEN-1:XLEN]};
        quo = acc_q[XLEN-1:0];
        for (int i = 0; i < B; i++) begin
            rem = {rem[XLEN-1:0], quo[XLEN-1]};
            quo = quo << 1;
            if (rem >= {1'b0, x_q}) begin
                rem    = rem - {1'b0, x_q};
                quo[0] = 1'b1;
            end
        end
        acc_div = {rem[XLEN-1:0], quo};

`ifdef MULDIV_EARLY_OUT_EN
        early  = !is_div && (y_next == '0);
        mshift = wsh + int'(cnt_q) * B;
`else
        early  = 1'b0;
        mshift = wsh;
`endif
        calc_done = (cnt_q == '0) || early;

        // The product sits left-justified by the number of multiplier bits not consumed.
        prod = acc_mul >> mshift;
        if (neg_q) prod = -prod;
        dres = is_rem ? acc_div[2*XLEN-1:XLEN] : acc_div[XLEN-1:0];
        if (neg_q) dres = -dres;
        if (is_div)                 calc_raw = dres;
        else if (op_q[1:0] == 2'b00) calc_raw = prod[XLEN-1:0];
        else                        calc_raw = prod[2*XLEN-1:XLEN];
        calc_res = w_op ? sext32(calc_raw) : calc_raw;
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        x_d      = x_q;
        y_d      = y_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        result_d = result_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start_i) begin
                    op_d    = op_i;
                    a_d     = op_a_i;
                    b_d     = op_b_i;
                    state_d = PREP;
                end
            end
            PREP: begin
                if (fast) begin
                    result_d = fast_res;
                    state_d  = DONE;
                end else begin
                    cnt_d   = CW'(w_op ? 32 / B - 1 : XLEN / B - 1);
                    neg_d   = is_rem ? a_neg : (a_neg ^ b_neg);
                    state_d = CALC;
                    if (is_div) begin
                        x_d   = b_mag;
                        y_d   = '0;
                        acc_d = {{XLEN{1'b0}}, a_mag << wsh};
                    end else begin
                        x_d   = a_mag;
                        y_d   = b_mag;
                        acc_d = '0;
                    end
                end
            end
            CALC: begin
                acc_d = is_div ? acc_div : acc_mul;
                y_d   = y_next;
                cnt_d = cnt_q - 1'b1;
                if (calc_done) begin
                    result_d = calc_res;
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Flush wins over everything, including a same-cycle start or completion.
        if (flush_i) begin
            state_d  = IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            x_q      <= '0;
            y_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            x_q      <= x_d;
            y_q      <= y_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    assign busy_o   = (state_q == PREP) || (state_q == CALC);
    assign valid_o  = (state_q == DONE);
    assign result_o = result_q;
endmodule

// File: doc/muldiv_iter.md
Name: muldiv_iter

Overview:
- Parametrised iterative RV M-extension execute unit; successor to the fixed-width single-op multiplier in the EX stage.
- Covers MUL/MULH/MULHSU/MULHU, DIV/DIVU/REM/REMU and the RV64 W variants in one shared shift/add-subtract datapath.
- Start/busy/valid handshake; the core drives stall_global from busy_o.
- Width and radix are set by parameters.

Parameters:
- XLEN, 64, operand/result width; legal values 32 or 64.
- BITS_PER_CYCLE, 1, quotient/multiplier bits retired per iteration; legal 1, 2, 4; must divide 32.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start_i  in  1  request; sampled only in IDLE or DONE
- op_i  in  4  [2:0]: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU; [3]: W variant
- op_a_i  in  XLEN  rs1 value (forwarded)
- op_b_i  in  XLEN  rs2 value (forwarded)
- flush_i  in  1  abort in-flight operation (branch redirect)
- busy_o  out  1  high in PREP and CALC
- valid_o  out  1  one-cycle result strobe
- result_o  out  XLEN  result; held until the next accepted start

Behaviour:
- Reset (async, any state): state=IDLE; busy_o=0, valid_o=0, result_o=0, all datapath registers 0.
- States: IDLE, PREP, CALC, DONE.
- Accept: start_i=1 && state in {IDLE, DONE} && !flush_i. Latches op, operands and sign flags, then goes to PREP.
- Back-to-back: start_i in DONE is accepted; valid_o is still 1 in that cycle.
- start_i while busy is ignored.
- PREP (1 cycle):
  - W variant (XLEN=64 only): operands are the low 32 bits, sign-extended for signed ops and zero-extended otherwise. Iteration count N=32/BITS_PER_CYCLE. Otherwise N=XLEN/BITS_PER_CYCLE.
  - op_i[3] is ignored when XLEN=32.
  - Signed operands are converted to magnitudes; the result-negate flag is recorded.
  - Fast path, PREP goes directly to DONE:
    - Divide by zero: quotient = all ones; remainder = dividend.
    - Signed overflow (most-negative / -1, at the effective width): quotient = dividend; remainder = 0.
  - All other ops go to CALC with iteration counter = N-1.
- CALC:
  - Multiply: shift-add into a 2*width product register.
  - Divide: restoring division, BITS_PER_CYCLE quotient bits per cycle.
  - Counter decrements each cycle; at counter==0 the fix-up is applied and the state goes to DONE.
- Fix-up:
  - Negate the product or quotient when signs differ.
  - Remainder takes the dividend's sign.
  - Select bits: MUL = low half; MULH* = high half; DIV* = quotient; REM* = remainder.
  - W variants: sign-extend bit 31 to 64 bits.
- DONE: valid_o=1 for exactly one cycle; result_o registered. Next state is IDLE, or PREP if a new start is accepted.
- Latency, from the accepting edge to the valid_o cycle:
  - Normal ops: N+2 cycles (XLEN=64, BITS_PER_CYCLE=1: 66; W ops: 34).
  - Fast path: 2 cycles.
- flush_i:
  - Any state goes to IDLE on the next edge; no valid_o.
  - flush_i has priority over start_i in the same cycle.
  - result_o keeps its last value.
- Simultaneous flush_i in DONE: valid_o is still high in that cycle; the state then goes to IDLE.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined:
  - Multiply CALC ends early once the remaining multiplier bits are all zero; the product is shifted into final alignment in the same cycle.
  - MUL with either operand zero takes the fast path with result 0.
  - busy_o and valid_o follow the actual, variable latency.
- Undefined: latency is fixed as listed above.
- Division is unaffected in both cases.

Test Plan:
- XLEN=64, BITS_PER_CYCLE=1: MUL a=7, b=-3 → valid_o at cycle 66, result_o=0xFFFFFFFFFFFFFFEB; busy_o high on cycles 1..65.
- MULHU a=0xFFFFFFFFFFFFFFFF, b=0xFFFFFFFFFFFFFFFF → 0xFFFFFFFFFFFFFFFE; MULHSU a=-1, b=2 → 0xFFFFFFFFFFFFFFFF.
- DIV a=-20, b=6 → -3; REM same operands → -2; DIVU a=5, b=0 → 0xFFFFFFFFFFFFFFFF at cycle 2; REM a=0x8000000000000000, b=-1 → 0 at cycle 2.
- DIVW a=0x00000000_80000000, b=0xFFFFFFFF → 0xFFFFFFFF80000000 at cycle 2; MULW a=0x10000, b=0x10000 → 0 at cycle 34.
- flush_i at cycle 10 of a DIV → state IDLE, no valid_o, result_o unchanged; start_i with flush_i in the same cycle → not accepted.
- rst asserted mid-CALC → all outputs 0 immediately; back-to-back start in DONE → second result valid 66 cycles later; with MULDIV_EARLY_OUT_EN, MUL a=5, b=3 → valid_o by cycle 4.
